core_output_collector: RTL and testbench

- Downstream stage of the multicore array. It consumes the per-core result words (32-bit signed) and their output strobes from all cores.
- It serializes them into one valid/ready stream tagged with the source core index, for the file-writer/host interface.
- Each core gets a one-word holding slot. A round-robin arbiter drains the slots into a shared output FIFO.
- Lost words are flagged and counted, never silently discarded.

---
 rtl/core_output_collector.sv | 146 ++++++++++++++
 tb/tb_core_output_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_output_collector.sv
// ============================================================================
// Module   : core_output_collector
// Purpose  : Per-core holding slots drained round-robin into a tagged output FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_output_collector #(
  parameter int NCORES = 111,
  parameter int DW     = 32,
  parameter int SRCW   = 7,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCORES*DW-1:0]   i_core_data,
  input  logic [NCORES-1:0]      i_core_en,
  output logic [DW-1:0]          o_out_data,
  output logic [SRCW-1:0]        o_out_src,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_overflow,
  output logic [15:0]            o_drop_cnt,
  output logic [$clog2(DEPTH):0] o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0]     r_slot     [NCORES];
  logic [NCORES-1:0] r_pend;
  logic [SRCW-1:0]   r_rr_ptr;
  logic [DW-1:0]     r_mem_data [DEPTH];
  logic [SRCW-1:0]   r_mem_src  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_count;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic              w_pop;
  logic              w_push_ok;
  logic              w_push;
  logic              w_hi_found;
  logic              w_lo_found;
  logic [SRCW-1:0]   w_hi_grant;
  logic [SRCW-1:0]   w_lo_grant;
  logic [SRCW-1:0]   w_grant;
  logic [NCORES-1:0] w_gnt_vec;
  logic [NCORES-1:0] w_take;
  logic [NCORES-1:0] w_drop;
  logic [16:0]       w_ndrop;
  logic [16:0]       w_drop_sum;

  assign o_out_valid  = (r_count != '0);
  assign o_out_data   = o_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_out_src    = o_out_valid ? r_mem_src[r_rd_ptr]  : '0;
  assign o_overflow   = r_overflow;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_fifo_level = r_count;

  assign w_pop     = o_out_valid && i_out_ready;
  assign w_push_ok = (r_count < LW'(DEPTH)) || w_pop;

  // Two-pass priority search: lowest pending index at or above rr_ptr, else lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_grant = '0;
    w_lo_found = 1'b0;
    w_lo_grant = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_lo_found = 1'b1;
        w_lo_grant = SRCW'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_grant = SRCW'(i);
        end
      end
    end
  end

  assign w_grant = w_hi_found ? w_hi_grant : w_lo_grant;
  assign w_push  = w_push_ok && w_lo_found;

  always_comb begin
    w_gnt_vec = '0;
    w_take    = '0;
    w_drop    = '0;
    for (int i = 0; i < NCORES; i++) begin
      w_gnt_vec[i] = w_push && (w_grant == SRCW'(i));
      w_take[i]    = i_core_en[i] && (!r_pend[i] || w_gnt_vec[i]);
      w_drop[i]    = i_core_en[i] && r_pend[i] && !w_gnt_vec[i];
    end
  end

  assign w_ndrop    = 17'($countones(w_drop));
  assign w_drop_sum = {1'b0, r_drop_cnt} + w_ndrop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      // A same-edge capture wins over the grant's clear, so the refill stays pending.
      r_pend <= (r_pend & ~w_gnt_vec) | w_take;
      if (w_push) begin
        r_rr_ptr <= (w_grant == SRCW'(NCORES - 1)) ? '0 : w_grant + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (|w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  // Storage is qualified by pend bits and the count, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++) begin
      if (w_take[i]) begin
        r_slot[i] <= i_core_data[i*DW +: DW];
      end
    end
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= r_slot[w_grant];
      r_mem_src[r_wr_ptr]  <= w_grant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_output_collector.sv
// ============================================================================
// Module   : tb_core_output_collector
// Purpose  : Directed self-checking bench for core_output_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_output_collector;

  localparam int NC    = 111;
  localparam int DW    = 32;
  localparam int SW    = 7;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC*DW-1:0] core_data = '0;
  logic [NC-1:0]    core_en = '0;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic [4:0]       fifo_level;

  int checks = 0;
  int errors = 0;

  core_output_collector #(.NCORES(NC), .DW(DW), .SRCW(SW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_core_data  (core_data),
    .i_core_en    (core_en),
    .o_out_data   (out_data),
    .o_out_src    (out_src),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_overflow   (overflow),
    .o_drop_cnt   (drop_cnt),
    .o_fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int idx, input logic [31:0] val);
    core_data[idx*DW +: DW] = val;
    core_en[idx] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    core_en   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the head word, checks it, then pops it (out_ready must be 1).
  task automatic expect_word(input string tag, input int src, input logic [31:0] data);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 64'(n < 50), 64'd1);
    chk({tag, "_src"}, 64'(out_src), 64'(src));
    chk({tag, "_data"}, 64'(out_data), 64'(data));
    tick();
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    do_reset();

    // Single word: two-edge latency, then popped
    out_ready = 1'b1;
    set_core(5, 32'hFFFF_FFF9);
    tick();
    core_en = '0;
    chk("single_lat1", 64'(out_valid), 64'd0);
    tick();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hFFFF_FFF9);
    chk("single_src", 64'(out_src), 64'd5);
    tick();
    chk("single_gone", 64'(out_valid), 64'd0);

    // Simultaneous strobe of all cores
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) set_core(i, 32'(i * 3));
    tick();
    core_en = '0;
    for (int k = 0; k < NC; k++) expect_word($sformatf("all%0d", k), k, 32'(k * 3));
    chk("all_empty", 64'(out_valid), 64'd0);
    chk("all_ovf", 64'(overflow), 64'd0);

    // Round-robin wrap: grant 108 puts rr_ptr at 109
    set_core(108, 32'd1108);
    tick();
    core_en = '0;
    expect_word("rr108", 108, 32'd1108);
    set_core(2, 32'd1002);
    set_core(110, 32'd1110);
    tick();
    core_en = '0;
    expect_word("rr110", 110, 32'd1110);
    expect_word("rr2", 2, 32'd1002);
    // rr_ptr now 3: core 3 must beat core 1
    set_core(1, 32'd1001);
    set_core(3, 32'd1003);
    tick();
    core_en = '0;
    expect_word("rr3", 3, 32'd1003);
    expect_word("rr1", 1, 32'd1001);

    // Back-pressure with 20 strobes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 20; i++) set_core(i, 32'(500 + i));
    tick();
    core_en = '0;
    repeat (25) tick();
    chk("bp_level", 64'(fifo_level), 64'd16);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_src", 64'(out_src), 64'd0);
    chk("bp_data", 64'(out_data), 64'd500);
    repeat (5) tick();
    chk("bp_hold_level", 64'(fifo_level), 64'd16);
    chk("bp_hold_data", 64'(out_data), 64'd500);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) expect_word($sformatf("bp%0d", k), k, 32'(500 + k));
    chk("bp_level_end", 64'(fifo_level), 64'd0);
    chk("bp_ovf", 64'(overflow), 64'd0);
    chk("bp_drop", 64'(drop_cnt), 64'd0);

    // Drop on a full FIFO, then same-edge refill of a granted slot
    do_reset();
    for (int i = 0; i < 16; i++) set_core(i, 32'(300 + i));
    tick();
    core_en = '0;
    n = 0;
    while (fifo_level !== 5'd16 && n < 40) begin
      tick();
      n++;
    end
    chk("drop_full", 64'(fifo_level), 64'd16);
    set_core(7, 32'hAAAA_0007);
    tick();
    set_core(7, 32'hBBBB_0007);
    tick();
    core_en = '0;
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_cnt1", 64'(drop_cnt), 64'd1);
    chk("drop_head_src", 64'(out_src), 64'd0);
    chk("drop_head_data", 64'(out_data), 64'd300);
    set_core(7, 32'hCCCC_0007);
    out_ready = 1'b1;
    tick();
    core_en = '0;
    chk("refill_drop", 64'(drop_cnt), 64'd1);
    for (int k = 1; k < 16; k++) expect_word($sformatf("drop%0d", k), k, 32'(300 + k));
    expect_word("drop_A", 7, 32'hAAAA_0007);
    expect_word("drop_C", 7, 32'hCCCC_0007);
    chk("drop_empty", 64'(out_valid), 64'd0);
    chk("drop_cnt_end", 64'(drop_cnt), 64'd1);

    // Asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 20; i++) set_core(i, 32'(700 + i));
    tick();
    core_en = '0;
    set_core(19, 32'd9999);
    tick();
    core_en = '0;
    chk("ar_pre_ovf", 64'(overflow), 64'd1);
    chk("ar_pre_drop", 64'(drop_cnt), 64'd1);
    n = 0;
    while (fifo_level !== 5'd9 && n < 30) begin
      tick();
      n++;
    end
    chk("ar_level9", 64'(fifo_level), 64'd9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_level", 64'(fifo_level), 64'd0);
    chk("ar_ovf", 64'(overflow), 64'd0);
    chk("ar_drop", 64'(drop_cnt), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_core(0, 32'h0000_1234);
    tick();
    core_en = '0;
    chk("ar_post_lat1", 64'(out_valid), 64'd0);
    tick();
    chk("ar_post_valid", 64'(out_valid), 64'd1);
    chk("ar_post_src", 64'(out_src), 64'd0);
    chk("ar_post_data", 64'(out_data), 64'h1234);
    tick();
    chk("ar_post_empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
